// File: rtl/pixel_fetch_ctrl.sv
// pixel_fetch_ctrl: fetches 3x3 luma windows over a bus,
// hands them to a compute stage and writes back the result.
module pixel_fetch_ctrl #(
  parameter int IMG_WIDTH  = 428,
  parameter int IMG_HEIGHT = 428,
  parameter int WR_BASE    = 183184
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        stop,
  input  logic [31:0] hrdata,
  input  logic        hready,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic        win_valid,
  output logic [71:0] win_data,
  input  logic        res_valid,
  input  logic [7:0]  res_data,
  output logic        done
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WIN, S_WR, S_ADV, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [3:0]    r_k;
  logic [71:0]   r_win;
  logic [7:0]    r_res;
  logic [31:0]   r_haddr_last;

  logic [1:0]    w_kr;
  logic [1:0]    w_kc;
  logic [31:0]   w_rd_addr;
  logic [31:0]   w_wr_addr;
  logic [9:0]    w_luma10;
  logic          w_last_col;
  logic          w_last_row;

  // split window index k into row/column offsets
  always_comb begin
    w_kr = 2'd0;
    w_kc = 2'd0;
    case (r_k)
      4'd0: begin w_kr = 2'd0; w_kc = 2'd0; end
      4'd1: begin w_kr = 2'd0; w_kc = 2'd1; end
      4'd2: begin w_kr = 2'd0; w_kc = 2'd2; end
      4'd3: begin w_kr = 2'd1; w_kc = 2'd0; end
      4'd4: begin w_kr = 2'd1; w_kc = 2'd1; end
      4'd5: begin w_kr = 2'd1; w_kc = 2'd2; end
      4'd6: begin w_kr = 2'd2; w_kc = 2'd0; end
      4'd7: begin w_kr = 2'd2; w_kc = 2'd1; end
      default: begin w_kr = 2'd2; w_kc = 2'd2; end
    endcase
  end

  assign w_rd_addr = (32'(r_row) + 32'(w_kr)) * 32'(IMG_WIDTH)
                   + 32'(r_col) + 32'(w_kc);
  assign w_wr_addr = 32'(WR_BASE) + 32'(r_row) * 32'(IMG_WIDTH)
                   + 32'(r_col);
  assign w_luma10  = {2'b0, hrdata[23:16]}
                   + {1'b0, hrdata[15:8], 1'b0}
                   + {2'b0, hrdata[7:0]};
  assign w_last_col = (r_col == CW'(IMG_WIDTH - 3));
  assign w_last_row = (r_row == RW'(IMG_HEIGHT - 3));

  // bus outputs decode from state; haddr keeps its last value otherwise
  always_comb begin
    haddr = r_haddr_last;
    case (r_state)
      S_RD_REQ, S_RD_WAIT: haddr = w_rd_addr;
      S_WR:                haddr = w_wr_addr;
      default:             haddr = r_haddr_last;
    endcase
  end

  assign hwrite    = (r_state == S_WR);
  assign hwdata    = {8'h00, r_res, r_res, r_res};
  assign win_valid = (r_state == S_WIN);
  assign win_data  = r_win;
  assign done      = (r_state == S_DONE);

  // next-state logic, stop overrides every handshake
  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_RD_REQ;
        S_RD_REQ:  w_next = S_RD_WAIT;
        S_RD_WAIT: if (hready) w_next = (r_k == 4'd8) ? S_WIN : S_RD_REQ;
        S_WIN:     if (res_valid) w_next = S_WR;
        S_WR:      if (hready) w_next = S_ADV;
        S_ADV:     w_next = (w_last_row && w_last_col) ? S_DONE : S_RD_REQ;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // counters, window capture, result latch and address memory
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_k          <= '0;
      r_win        <= '0;
      r_res        <= '0;
      r_haddr_last <= '0;
    end else if (stop) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else begin
      if (r_state == S_RD_REQ || r_state == S_RD_WAIT || r_state == S_WR)
        r_haddr_last <= haddr;
      case (r_state)
        S_RD_WAIT: if (hready) begin
          r_win[{r_k, 3'b000} +: 8] <= w_luma10[9:2];
          if (r_k != 4'd8) r_k <= r_k + 4'd1;
        end
        S_WIN: if (res_valid) r_res <= res_data;
        S_ADV: begin
          r_k <= '0;
          if (!w_last_col) begin
            r_col <= r_col + CW'(1);
          end else begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// tb_pixel_fetch_ctrl: directed bench for a 4x4 image,
// bus handshakes driven on the falling edge.
module tb_pixel_fetch_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        stop;
  logic [31:0] hrdata;
  logic        hready;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic        win_valid;
  logic [71:0] win_data;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  pixel_fetch_ctrl #(
    .IMG_WIDTH(4), .IMG_HEIGHT(4), .WR_BASE(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .stop(stop),
    .hrdata(hrdata), .hready(hready),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
    .win_valid(win_valid), .win_data(win_data),
    .res_valid(res_valid), .res_data(res_data),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // one read: entered at a falling edge while in RD_REQ
  task automatic rd(input logic [31:0] ea, input logic [31:0] d,
                    input int w, input bit pulse_res);
    chk("rd_addr", 72'(haddr), 72'(ea));
    chk("rd_hwrite", 72'(hwrite), 72'(0));
    hrdata = d;
    @(negedge clk);
    if (pulse_res) begin
      res_valid = 1'b1;
      res_data  = 8'hAA;
      @(negedge clk);
      res_valid = 1'b0;
    end
    repeat (w) @(negedge clk);
    chk("rd_hold", 72'(haddr), 72'(ea));
    hready = 1'b1;
    @(negedge clk);
    hready = 1'b0;
  endtask

  // one full output pixel; data mode selects hrdata and expected luma
  task automatic pixel(input int r, input int c, input int mode,
                       input logic [7:0] res, input logic [31:0] ewa,
                       input bit late_res, input bit abort_wr);
    logic [71:0] ew;
    logic [31:0] d;
    logic [7:0]  v;
    ew = '0;
    for (int k = 0; k < 9; k++) begin
      case (mode)
        0: begin d = 32'h0040_80C0; v = 8'h80; end
        1: begin
          v = 8'(r * 64 + c * 32 + k * 3 + 1);
          d = {8'h00, v, v, v};
        end
        2: begin d = 32'h00FF_1003; v = 8'h48; end
        default: begin d = 32'h00FF_FFFF; v = 8'hFF; end
      endcase
      ew[k*8 +: 8] = v;
      rd(32'((r + k / 3) * 4 + c + k % 3), d,
         abort_wr ? 0 : $urandom_range(0, 2),
         late_res && (k == 3));
    end
    chk("win_valid", 72'(win_valid), 72'(1));
    chk("win_data", win_data, ew);
    if (late_res) begin
      repeat (3) @(negedge clk);
      chk("win_hold", 72'(win_valid), 72'(1));
      chk("win_nowr", 72'(hwrite), 72'(0));
    end
    res_valid = 1'b1;
    res_data  = res;
    @(negedge clk);
    res_valid = 1'b0;
    chk("wr_hwrite", 72'(hwrite), 72'(1));
    chk("wr_addr", 72'(haddr), 72'(ewa));
    chk("wr_data", 72'(hwdata), 72'({8'h00, res, res, res}));
    if (abort_wr) return;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("wr_hold", 72'(haddr), 72'(ewa));
    hready = 1'b1;
    @(negedge clk);
    hready = 1'b0;
    chk("adv_hwrite", 72'(hwrite), 72'(0));
    @(negedge clk);
  endtask

  initial begin
    n_rst     = 1'b0;
    stop      = 1'b1;
    hrdata    = '0;
    hready    = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    #12;
    chk("rst_haddr", 72'(haddr), 72'(0));
    chk("rst_hwrite", 72'(hwrite), 72'(0));
    chk("rst_hwdata", 72'(hwdata), 72'(0));
    chk("rst_win_v", 72'(win_valid), 72'(0));
    chk("rst_win_d", win_data, 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("stop_idle_addr", 72'(haddr), 72'(0));
    chk("stop_idle_wr", 72'(hwrite), 72'(0));
    stop = 1'b0;
    @(negedge clk);

    // full image: writes at 16, 17, 20, 21
    pixel(0, 0, 0, 8'h55, 32'd16, 1'b0, 1'b0);
    pixel(0, 1, 1, 8'h12, 32'd17, 1'b0, 1'b0);
    pixel(1, 0, 2, 8'hC3, 32'd20, 1'b0, 1'b0);
    pixel(1, 1, 3, 8'h7E, 32'd21, 1'b0, 1'b0);
    chk("done_rise", 72'(done), 72'(1));
    chk("done_hwrite", 72'(hwrite), 72'(0));
    chk("done_haddr", 72'(haddr), 72'(21));
    hready    = 1'b1;
    res_valid = 1'b1;
    repeat (5) @(negedge clk);
    hready    = 1'b0;
    res_valid = 1'b0;
    chk("done_stay", 72'(done), 72'(1));

    stop = 1'b1;
    @(negedge clk);
    chk("stop_done", 72'(done), 72'(0));
    stop = 1'b0;
    @(negedge clk);

    // res_valid during RD_WAIT is ignored; later strobe writes
    pixel(0, 0, 1, 8'h33, 32'd16, 1'b1, 1'b0);

    // abort in RD_WAIT of pixel (0,1)
    chk("p01_addr", 72'(haddr), 72'(1));
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("abort_hwrite", 72'(hwrite), 72'(0));
    chk("abort_win", 72'(win_valid), 72'(0));
    @(negedge clk);
    chk("restart_addr", 72'(haddr), 72'(0));
    chk("restart_wr", 72'(hwrite), 72'(0));

    // asynchronous reset in the middle of a write
    pixel(0, 0, 0, 8'h99, 32'd16, 1'b0, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_hwrite", 72'(hwrite), 72'(0));
    chk("arst_win", 72'(win_valid), 72'(0));
    chk("arst_haddr", 72'(haddr), 72'(0));
    chk("arst_hwdata", 72'(hwdata), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
